// File: rtl/serial_io_scanner.sv
// Serial I/O chain engine: per frame, loads the input chain, shifts the output word out
// while shifting the input word in, then latches the output chain and publishes the capture.
module serial_io_scanner #(
    parameter int OUT_WIDTH = 16,
    parameter int IN_WIDTH  = 21,
    parameter int CLK_DIV   = 4,
    parameter int LSB_FIRST = 0
) (
    input  logic                 i_CLK,
    input  logic                 i_RESET,
    input  logic                 i_Enable,
    input  logic [OUT_WIDTH-1:0] i_Data,
    input  logic                 i_SData,
    output logic                 o_SCLK,
    output logic                 o_SData,
    output logic                 o_InLoad,
    output logic                 o_OutLatch,
    output logic [IN_WIDTH-1:0]  o_InData,
    output logic                 o_InValid,
    output logic                 o_InChanged,
    output logic                 o_Busy
);
    localparam int N  = (OUT_WIDTH > IN_WIDTH) ? OUT_WIDTH : IN_WIDTH;
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

    state_t                state, state_n;
    logic [CW-1:0]         div_cnt;
    logic                  tick;
    logic                  phase, phase_n;
    logic [BW-1:0]         bit_cnt, bit_cnt_n;
    logic [N-1:0]          sreg, sreg_n;
    logic [IN_WIDTH-1:0]   cap, cap_n;
    logic                  frame_done;
    logic                  sbit_n;

    assign tick = (div_cnt == CW'(CLK_DIV - 1));

    always_comb begin
        state_n    = state;
        phase_n    = phase;
        bit_cnt_n  = bit_cnt;
        sreg_n     = sreg;
        cap_n      = cap;
        frame_done = 1'b0;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (i_Enable) begin
                        state_n = LOAD;
                        // Padding zeros sit at the end that is shifted out first.
                        sreg_n = (LSB_FIRST != 0) ? (N'(i_Data) << (N - OUT_WIDTH)) : N'(i_Data);
                    end
                end
                LOAD: begin
                    state_n   = SHIFT;
                    phase_n   = 1'b0;
                    bit_cnt_n = '0;
                end
                SHIFT: begin
                    if (!phase) begin
                        phase_n = 1'b1;
                        if (32'(bit_cnt) < IN_WIDTH) begin
                            cap_n = (LSB_FIRST != 0)
                                  ? ((cap >> 1) | (IN_WIDTH'(i_SData) << (IN_WIDTH - 1)))
                                  : ((cap << 1) | IN_WIDTH'(i_SData));
                        end
                    end else begin
                        phase_n = 1'b0;
                        sreg_n  = (LSB_FIRST != 0) ? (sreg >> 1) : (sreg << 1);
                        if (bit_cnt == BW'(N - 1)) begin
                            state_n = LATCH;
                        end else begin
                            bit_cnt_n = bit_cnt + BW'(1);
                        end
                    end
                end
                LATCH: begin
                    state_n    = IDLE;
                    frame_done = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign sbit_n = (LSB_FIRST != 0) ? sreg_n[0] : sreg_n[N-1];

    // Outputs are registered from next-state values so they align with the state register.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            state       <= IDLE;
            div_cnt     <= '0;
            phase       <= 1'b0;
            bit_cnt     <= '0;
            sreg        <= '0;
            cap         <= '0;
            o_SCLK      <= 1'b0;
            o_SData     <= 1'b0;
            o_InLoad    <= 1'b0;
            o_OutLatch  <= 1'b0;
            o_InData    <= '0;
            o_InValid   <= 1'b0;
            o_InChanged <= 1'b0;
            o_Busy      <= 1'b0;
        end else begin
            div_cnt     <= tick ? '0 : div_cnt + CW'(1);
            state       <= state_n;
            phase       <= phase_n;
            bit_cnt     <= bit_cnt_n;
            sreg        <= sreg_n;
            cap         <= cap_n;
            o_SCLK      <= (state_n == SHIFT) && phase_n;
            o_SData     <= (state_n == SHIFT) ? sbit_n : 1'b0;
            o_InLoad    <= (state_n == LOAD);
            o_OutLatch  <= (state_n == LATCH);
            o_Busy      <= (state_n != IDLE);
            o_InValid   <= frame_done;
            o_InChanged <= frame_done && (cap != o_InData);
            if (frame_done) begin
                o_InData <= cap;
            end
        end
    end
endmodule

// File: tb/tb_serial_io_scanner.sv
// Bench for serial_io_scanner: three configurations driven with random frames and
// checked against a bit-order model of the output and input serial chains.
module tb_serial_io_scanner;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] en;
    logic [2:0] sdi = '0;
    logic [2:0] sclk, sdo, inload, outlatch, invalid, inchg, busy;
    logic [7:0] din_a, din_c;
    logic [3:0] din_b;
    logic [7:0] ind_a, ind_c;
    logic [5:0] ind_b;

    int c_out [3] = '{8, 4, 8};
    int c_in  [3] = '{8, 6, 8};
    int c_cd  [3] = '{2, 3, 1};
    int c_lsb [3] = '{0, 0, 1};

    int n_cmp = 0;
    int n_bad = 0;

    int          sout_n [3];
    int          sin_idx [3];
    int          latch_cyc [3];
    int          load_cyc [3];
    int          valid_cyc [3];
    int          busy_cyc [3];
    bit          sout_seen [3][64];
    bit          sin_bits [3][64];
    logic [2:0]  sclk_q = '0;
    logic [63:0] exp_prev [3];

    always #5 clk = ~clk;

    serial_io_scanner #(.OUT_WIDTH(8), .IN_WIDTH(8), .CLK_DIV(2), .LSB_FIRST(0)) u_a (
        .i_CLK(clk), .i_RESET(rst), .i_Enable(en[0]), .i_Data(din_a), .i_SData(sdi[0]),
        .o_SCLK(sclk[0]), .o_SData(sdo[0]), .o_InLoad(inload[0]), .o_OutLatch(outlatch[0]),
        .o_InData(ind_a), .o_InValid(invalid[0]), .o_InChanged(inchg[0]), .o_Busy(busy[0])
    );
    serial_io_scanner #(.OUT_WIDTH(4), .IN_WIDTH(6), .CLK_DIV(3), .LSB_FIRST(0)) u_b (
        .i_CLK(clk), .i_RESET(rst), .i_Enable(en[1]), .i_Data(din_b), .i_SData(sdi[1]),
        .o_SCLK(sclk[1]), .o_SData(sdo[1]), .o_InLoad(inload[1]), .o_OutLatch(outlatch[1]),
        .o_InData(ind_b), .o_InValid(invalid[1]), .o_InChanged(inchg[1]), .o_Busy(busy[1])
    );
    serial_io_scanner #(.OUT_WIDTH(8), .IN_WIDTH(8), .CLK_DIV(1), .LSB_FIRST(1)) u_c (
        .i_CLK(clk), .i_RESET(rst), .i_Enable(en[2]), .i_Data(din_c), .i_SData(sdi[2]),
        .o_SCLK(sclk[2]), .o_SData(sdo[2]), .o_InLoad(inload[2]), .o_OutLatch(outlatch[2]),
        .o_InData(ind_c), .o_InValid(invalid[2]), .o_InChanged(inchg[2]), .o_Busy(busy[2])
    );

    // External chains: the input chain presents its next bit after each SCLK rise,
    // and every SCLK rise records the bit seen by the output chain.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (inload[k]) begin
                sin_idx[k] = 0;
                sdi[k] = sin_bits[k][0];
                load_cyc[k]++;
            end
            if (sclk[k] && !sclk_q[k]) begin
                if (sout_n[k] < 64) sout_seen[k][sout_n[k]] = sdo[k];
                sout_n[k]++;
                sin_idx[k]++;
                if (sin_idx[k] < 64) sdi[k] = sin_bits[k][sin_idx[k]];
            end
            if (outlatch[k]) latch_cyc[k]++;
            if (invalid[k]) valid_cyc[k]++;
            if (busy[k]) busy_cyc[k]++;
        end
        sclk_q = sclk;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int n_of(input int k);
        return (c_out[k] > c_in[k]) ? c_out[k] : c_in[k];
    endfunction

    function automatic logic [63:0] get_ind(input int k);
        case (k)
            0:       return 64'(ind_a);
            1:       return 64'(ind_b);
            default: return 64'(ind_c);
        endcase
    endfunction

    task automatic set_din(input int k, input logic [63:0] v);
        case (k)
            0:       din_a = v[7:0];
            1:       din_b = v[3:0];
            default: din_c = v[7:0];
        endcase
    endtask

    // j-th bit on the output chain: leading padding zeros, then data in shift order.
    function automatic bit exp_sout(input int k, input logic [63:0] d, input int j);
        int pad = n_of(k) - c_out[k];
        int idx;
        if (j < pad) return 1'b0;
        idx = j - pad;
        return (c_lsb[k] != 0) ? d[idx] : d[c_out[k] - 1 - idx];
    endfunction

    function automatic logic [63:0] in_mask(input int k);
        return (64'd1 << c_in[k]) - 64'd1;
    endfunction

    task automatic load_chain(input int k, input logic [63:0] sword);
        for (int j = 0; j < 64; j++) begin
            if (j < c_in[k])
                sin_bits[k][j] = (c_lsb[k] != 0) ? sword[j] : sword[c_in[k] - 1 - j];
            else
                sin_bits[k][j] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic clear_counts(input int k);
        sout_n[k] = 0;
        latch_cyc[k] = 0;
        load_cyc[k] = 0;
        valid_cyc[k] = 0;
        busy_cyc[k] = 0;
    endtask

    task automatic start_frame(input int k, input logic [63:0] d);
        int t = 0;
        clear_counts(k);
        set_din(k, d);
        en[k] = 1'b1;
        while (!busy[k] && t < 200) begin
            @(negedge clk);
            t++;
        end
        check_val($sformatf("start%0d", k), 64'(busy[k]), 64'd1);
        en[k] = 1'b0;
    endtask

    task automatic run_frame(input int k, input logic [63:0] d, input logic [63:0] sword,
                             input bit scramble);
        int n = n_of(k);
        int cd = c_cd[k];
        int t = 0;
        logic [63:0] exp_word = sword & in_mask(k);
        load_chain(k, sword);
        start_frame(k, d);
        if (scramble) set_din(k, 64'($urandom));
        while (!invalid[k] && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check_val($sformatf("valid%0d", k), 64'(invalid[k]), 64'd1);
        check_val($sformatf("indata%0d", k), get_ind(k), exp_word);
        check_val($sformatf("changed%0d", k), 64'(inchg[k]), 64'(exp_word != exp_prev[k]));
        exp_prev[k] = exp_word;
        @(negedge clk);
        check_val($sformatf("valid_len%0d", k), 64'(valid_cyc[k]), 64'd1);
        check_val($sformatf("sclk_edges%0d", k), 64'(sout_n[k]), 64'(n));
        for (int j = 0; j < n; j++)
            check_val($sformatf("sdata%0d[%0d]", k, j), 64'(sout_seen[k][j]), 64'(exp_sout(k, d, j)));
        check_val($sformatf("latch_len%0d", k), 64'(latch_cyc[k]), 64'(cd));
        check_val($sformatf("load_len%0d", k), 64'(load_cyc[k]), 64'(cd));
        check_val($sformatf("busy_len%0d", k), 64'(busy_cyc[k]), 64'((2 * n + 2) * cd));
        check_val($sformatf("idle_after%0d", k), 64'(busy[k]), 64'd0);
    endtask

    // Enable held high: successive captures are one full frame apart.
    task automatic run_b2b(input int k);
        logic [63:0] sword = 64'($urandom);
        logic [63:0] exp_word = sword & in_mask(k);
        int t = 0;
        load_chain(k, sword);
        set_din(k, 64'($urandom));
        en[k] = 1'b1;
        while (!invalid[k] && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check_val($sformatf("b2b_first%0d", k), get_ind(k), exp_word);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!invalid[k] && t < 2000);
        en[k] = 1'b0;
        check_val($sformatf("b2b_period%0d", k), 64'(t), 64'((2 * n_of(k) + 3) * c_cd[k]));
        check_val($sformatf("b2b_same%0d", k), 64'(inchg[k]), 64'd0);
        exp_prev[k] = exp_word;
        t = 0;
        while (busy[k] && t < 1000) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < 3; k++) begin
            check_val($sformatf("%s_strobes%0d", tag, k),
                      64'({sclk[k], sdo[k], inload[k], outlatch[k], invalid[k], inchg[k], busy[k]}),
                      64'd0);
            check_val($sformatf("%s_indata%0d", tag, k), get_ind(k), 64'd0);
        end
    endtask

    task automatic reset_mid();
        int t = 0;
        load_chain(0, 64'($urandom));
        start_frame(0, 64'h5A);
        while (sout_n[0] < 4 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check_val("reached_bit3", 64'(sout_n[0]), 64'd4);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check_val("rst_no_latch", 64'(latch_cyc[0]), 64'd0);
        check_val("rst_no_valid", 64'(valid_cyc[0]), 64'd0);
        check_val("rst_indata", get_ind(0), 64'd0);
        for (int k = 0; k < 3; k++) exp_prev[k] = '0;
    endtask

    initial begin
        rst = 1'b1;
        en = '0;
        din_a = '0;
        din_b = '0;
        din_c = '0;
        for (int k = 0; k < 3; k++) begin
            exp_prev[k] = '0;
            clear_counts(k);
        end
        @(negedge clk);
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_frame(0, 64'hA5, 64'($urandom), 1'b0);
        run_frame(0, 64'($urandom), 64'h3C, 1'b0);
        run_frame(0, 64'($urandom), 64'h3C, 1'b0);
        run_frame(1, 64'hF, 64'b101100, 1'b0);
        run_frame(2, 64'h0F, 64'h01, 1'b0);

        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 3; k++) begin
                if (i == 3)
                    run_frame(k, 64'($urandom), exp_prev[k], 1'b1);
                else
                    run_frame(k, 64'($urandom), 64'($urandom), 1'b1);
            end
        end

        for (int k = 0; k < 3; k++) run_b2b(k);

        reset_mid();
        run_frame(0, 64'hA5, 64'($urandom), 1'b0);
        run_frame(1, 64'hF, 64'b101100, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/serial_io_scanner.md
# serial_io_scanner

Parametrised serial I/O chain controller that replaces the separate fixed-width LED shift-out and DIP shift-in drivers with one engine. It runs repeated frames. Each frame loads the external input shift registers, shifts out a parallel output word while it shifts in the input word, then latches the outputs. It sits between board-level serial chains (LEDs, 7-segment, DIP/switches) and core logic, and it reports when the captured input word changes.

## Interface
- OUT_WIDTH, 16: bits in the output chain (1..64)
- IN_WIDTH, 21: bits in the input chain (1..64)
- CLK_DIV, 4: i_CLK cycles per tick (>=1)
- LSB_FIRST, 0: 0 = MSB shifted first in both directions; 1 = LSB first
- i_CLK  in  1  single clock; all logic on its rising edge
- i_RESET  in  1  synchronous, active-high reset
- i_Enable  in  1  1 = run frames back to back; 0 = stop after the current frame
- i_Data  in  OUT_WIDTH  parallel word to shift out
- i_SData  in  1  serial data from the input chain
- o_SCLK  out  1  serial shift clock
- o_SData  out  1  serial data to the output chain
- o_InLoad  out  1  parallel-load strobe for the input chain (active high)
- o_OutLatch  out  1  commit strobe for the output chain (active high)
- o_InData  out  IN_WIDTH  last complete captured input word
- o_InValid  out  1  one-cycle pulse when o_InData updates
- o_InChanged  out  1  one-cycle pulse, coincident with o_InValid, when the new word differs from the previous o_InData
- o_Busy  out  1  1 in any state other than IDLE

## Operation
- N = max(OUT_WIDTH, IN_WIDTH) bit slots per frame.
- Prescaler counts 0..CLK_DIV-1. A tick occurs when it reaches CLK_DIV-1. All FSM steps happen only on ticks. With CLK_DIV=1 every cycle is a tick.
- FSM states: IDLE, LOAD, SHIFT, LATCH.
  - IDLE: on a tick with i_Enable=1, snapshot i_Data into the shift register and go to LOAD. Padding for OUT_WIDTH < N is N-OUT_WIDTH zeros, shifted before the data bits.
  - LOAD: o_InLoad=1 for one tick period, then go to SHIFT with bit=0, phase=0.
  - SHIFT phase 0: o_SCLK=0 and o_SData=current bit. On the next tick go to phase 1.
  - SHIFT phase 1: o_SCLK=1. i_SData is sampled on the i_CLK edge that raises o_SCLK. On the next tick, advance the bit. After bit N-1, go to LATCH.
  - LATCH: o_OutLatch=1 for one tick period. On the exiting tick: update o_InData, pulse o_InValid, pulse o_InChanged if the value differs, and go to IDLE.
- Input capture: only the first IN_WIDTH sampled bits are kept; the rest are discarded. With LSB_FIRST=0 the first bit goes to o_InData[IN_WIDTH-1]. With LSB_FIRST=1 it goes to o_InData[0].
- Changes on i_Data mid-frame have no effect until the next IDLE snapshot.
- If i_Enable falls mid-frame, the frame completes normally and the FSM stays in IDLE.

## Timing
- Reset values: all outputs 0, o_InData=0, prescaler=0, state IDLE.
- Frame length with i_Enable held high: (2N+3) ticks = (2N+3)*CLK_DIV i_CLK cycles. This is IDLE 1 + LOAD 1 + SHIFT 2N + LATCH 1.
- o_SData is stable for a full tick period before and after each o_SCLK rising edge.
- o_InLoad and o_OutLatch each stay high for exactly CLK_DIV cycles.
- o_InValid and o_InChanged are high for exactly 1 i_CLK cycle, on the cycle after the LATCH exit edge.
- o_InChanged on the first frame after reset compares against 0.
- Reset asserted mid-frame:
  - aborts the frame on the next edge;
  - produces no o_OutLatch and no o_InValid;
  - leaves o_InData=0 and all strobes 0 on the following cycle.
- Reset has priority over every other input.
- Registered outputs only; no combinational path from any input to any output.

## Test plan
- Reset: hold i_RESET for 3 cycles mid-run -> all outputs 0 on the cycle after the first reset edge; the next frame starts with IDLE.
- OUT=IN=8, CLK_DIV=2, i_Data=8'hA5, i_Enable pulsed for one frame -> on the 8 o_SCLK rising edges o_SData reads 1,0,1,0,0,1,0,1. One o_OutLatch pulse of 2 cycles follows. The frame lasts 38 cycles and o_Busy is then 0.
- OUT=IN=8, i_SData driving 8'h3C MSB-first -> o_InData=8'h3C with o_InValid=1 and o_InChanged=1. Repeat the same word -> o_InValid=1 and o_InChanged=0.
- OUT=4, IN=6, i_Data=4'hF, i_SData driving 6'b101100 -> o_SData reads 0,0,1,1,1,1; o_InData=6'b101100; 15 ticks per frame.
- Reset at SHIFT bit 3 -> no o_OutLatch and no o_InValid; o_InData=0. The next frame with i_Data=8'hA5 matches the second scenario.
- LSB_FIRST=1, i_Data=8'h0F -> o_SData reads 1,1,1,1,0,0,0,0. i_SData bits 1,0,0,0,0,0,0,0 -> o_InData=8'h01.
